// File: rtl/braille_to_ascii_display.sv
`default_nettype none
// ============================================================================
// braille_to_ascii_display: 6-dot Braille letter -> ASCII 65..90 on two
// registered 7-segment digits (tens, units). Rev 1.0
// ============================================================================
module braille_to_ascii_display (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] braille,
   output logic [6:0] digit_1,
   output logic [6:0] digit_2,
   output logic       valid
);

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;

   logic       letter_ok;
   logic [6:0] ascii;
   logic [7:0] bcd;

   function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
      logic [14:0] sh;
      sh = {8'd0, bin};
      for (int i = 0; i < 7; i++) begin
         if (sh[10:7] >= 4'd5)  sh[10:7]  = sh[10:7]  + 4'd3;
         if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
         sh = sh << 1;
      end
      return sh[14:7];
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   always_comb begin
      letter_ok = 1'b1;
      ascii     = 7'd0;
      case (braille)
         6'b100000: ascii = 7'd65;
         6'b110000: ascii = 7'd66;
         6'b100100: ascii = 7'd67;
         6'b100110: ascii = 7'd68;
         6'b100010: ascii = 7'd69;
         6'b110100: ascii = 7'd70;
         6'b110110: ascii = 7'd71;
         6'b110010: ascii = 7'd72;
         6'b010100: ascii = 7'd73;
         6'b010110: ascii = 7'd74;
         6'b101000: ascii = 7'd75;
         6'b111000: ascii = 7'd76;
         6'b101100: ascii = 7'd77;
         6'b101110: ascii = 7'd78;
         6'b101010: ascii = 7'd79;
         6'b111100: ascii = 7'd80;
         6'b111110: ascii = 7'd81;
         6'b111010: ascii = 7'd82;
         6'b011100: ascii = 7'd83;
         6'b011110: ascii = 7'd84;
         6'b101001: ascii = 7'd85;
         6'b111001: ascii = 7'd86;
         6'b010111: ascii = 7'd87;
         6'b101101: ascii = 7'd88;
         6'b101111: ascii = 7'd89;
         6'b101011: ascii = 7'd90;
         default:   letter_ok = 1'b0;
      endcase
   end

   assign bcd = bin_to_bcd(ascii);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_1 <= SEG_BLANK;
         digit_2 <= SEG_BLANK;
         valid   <= 1'b0;
      end else begin
         digit_1 <= letter_ok ? seg7(bcd[7:4]) : SEG_DASH;
         digit_2 <= letter_ok ? seg7(bcd[3:0]) : SEG_DASH;
         valid   <= letter_ok;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_braille_to_ascii_display.sv
`default_nettype none
// Scoreboard bench for braille_to_ascii_display with a table-driven reference.
module tb_braille_to_ascii_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] braille = 6'b100100;
   logic [6:0] digit_1, digit_2;
   logic       valid;

   int n_checks = 0;
   int n_fail   = 0;
   int sweep_valid = 0;

   typedef struct {
      logic [5:0]  b;
      logic [14:0] exp;
      bit          sweep;
   } item_t;

   item_t exp_q[$];

   logic [5:0] letters [26] = '{
      6'b100000, 6'b110000, 6'b100100, 6'b100110, 6'b100010, 6'b110100,
      6'b110110, 6'b110010, 6'b010100, 6'b010110, 6'b101000, 6'b111000,
      6'b101100, 6'b101110, 6'b101010, 6'b111100, 6'b111110, 6'b111010,
      6'b011100, 6'b011110, 6'b101001, 6'b111001, 6'b010111, 6'b101101,
      6'b101111, 6'b101011};
   logic [6:0] segs [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   braille_to_ascii_display dut (
      .clk(clk), .rst(rst), .braille(braille),
      .digit_1(digit_1), .digit_2(digit_2), .valid(valid));

   always #5 clk = ~clk;

   function automatic logic [14:0] model(input logic [5:0] b);
      int code;
      for (int i = 0; i < 26; i++)
         if (letters[i] == b) begin
            code = 65 + i;
            return {segs[code / 10], segs[code % 10], 1'b1};
         end
      return {7'b0000001, 7'b0000001, 1'b0};
   endfunction

   task automatic apply(input logic [5:0] b, input logic r, input bit sw = 1'b0);
      item_t it;
      @(negedge clk);
      rst = r;
      braille = b;
      it.b = b;
      it.exp = r ? 15'd0 : model(b);
      it.sweep = sw;
      exp_q.push_back(it);
   endtask

   task automatic check_now(input string name, input logic [14:0] exp);
      n_checks++;
      if ({digit_1, digit_2, valid} !== exp) begin
         n_fail++;
         $display("FAIL %s: got d1=%b d2=%b v=%b, expected d1=%b d2=%b v=%b",
                  name, digit_1, digit_2, valid, exp[14:8], exp[7:1], exp[0]);
      end
   endtask

   // Monitor: one scoreboard entry retires per clock edge.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (it.sweep && valid === 1'b1) sweep_valid++;
            n_checks++;
            if ({digit_1, digit_2, valid} !== it.exp) begin
               n_fail++;
               $display("FAIL scoreboard braille=%b: got d1=%b d2=%b v=%b, expected d1=%b d2=%b v=%b",
                        it.b, digit_1, digit_2, valid, it.exp[14:8], it.exp[7:1], it.exp[0]);
            end
         end
      end
   end

   initial begin
      logic [5:0] stream [8] = '{6'b100100, 6'b101110, 6'b101010, 6'b111100,
                                 6'b111110, 6'b010111, 6'b101111, 6'b101011};
      logic [5:0] r;
      #2;
      check_now("reset_blank", 15'd0);
      apply(6'b100100, 1'b1);
      apply(6'b100100, 1'b0);
      // Literal spot-checks alongside the model
      @(posedge clk); #2;
      check_now("lit_67", {7'b1011111, 7'b1110000, 1'b1});
      foreach (stream[i]) apply(stream[i], 1'b0);
      apply(6'b100000, 1'b0);
      apply(6'b110100, 1'b0);
      apply(6'b010110, 1'b0);
      @(posedge clk); #2;
      check_now("lit_74", {7'b1110000, 7'b0110011, 1'b1});
      apply(6'b000000, 1'b0);
      apply(6'b111111, 1'b0);
      apply(6'b000001, 1'b0);
      apply(6'b111010, 1'b0);
      @(posedge clk); #2;
      check_now("lit_82", {7'b1111111, 7'b1101101, 1'b1});
      // Asynchronous reset between edges
      apply(6'b101011, 1'b0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_now("async_reset", 15'd0);
      repeat (3) apply(6'b101011, 1'b1);
      apply(6'b101011, 1'b0);
      for (int i = 0; i < 64; i++) apply(6'(i), 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 1) == 0) r = letters[$urandom_range(0, 25)];
         else r = 6'($urandom_range(0, 63));
         apply(r, 1'b0);
      end
      repeat (4) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      n_checks++;
      if (sweep_valid != 26) begin
         n_fail++;
         $display("FAIL sweep_valid_count: got %0d, expected 26", sweep_valid);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/braille_to_ascii_display.md
Name: braille_to_ascii_display

Overview:
- Translates one 6-dot Braille cell (letters A–Z) into the decimal ASCII code of the uppercase letter, 65..90.
- Drives that code as two active-high 7-segment digit patterns: tens and units.
- Sits between a Braille input source (switches or keypad) and a two-digit 7-segment display.
- Registered output stage on a single clock with asynchronous active-high reset.

Parameters:
- None. All widths are fixed: 6-bit cell, 7-bit segment patterns.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- braille  input  6  Braille cell; bit5=dot1, bit4=dot2, bit3=dot3, bit2=dot4, bit1=dot5, bit0=dot6; 1 = raised dot
- digit_1  output  7  tens-digit segment pattern
- digit_2  output  7  units-digit segment pattern
- valid  output  1  1 = braille input is a recognised letter

Behaviour:
- Reset:
  - Clock and reset: one clock (clk, rising edge); reset rst is asynchronous and active-high.
  - While rst=1: digit_1=7'b0000000, digit_2=7'b0000000 (display blank), valid=0.
  - After release, outputs update on the first rising clk edge.
- Latency:
  - Exactly 1 cycle. braille is sampled at rising edge N; digit_1, digit_2 and valid reflect it after edge N.
  - No input synchroniser; the source is synchronous to clk.
- Decode table (braille -> letter -> ASCII):
  - A 100000=65, B 110000=66, C 100100=67, D 100110=68, E 100010=69, F 110100=70
  - G 110110=71, H 110010=72, I 010100=73, J 010110=74, K 101000=75, L 111000=76
  - M 101100=77, N 101110=78, O 101010=79, P 111100=80, Q 111110=81, R 111010=82
  - S 011100=83, T 011110=84, U 101001=85, V 111001=86, W 010111=87, X 101101=88
  - Y 101111=89, Z 101011=90
- ASCII to digits:
  - Tens = 6..9, units = 0..9, split by a combinational binary-to-BCD conversion.
  - The 7-bit ASCII value is not exposed.
- Segment encoding:
  - bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; 1 = lit.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Invalid input (any of the other 38 patterns, including 000000):
  - digit_1 = digit_2 = 7'b0000001 (dash on both digits), valid=0.
- Valid input: valid=1.
- The input may change every cycle; each registered result depends only on the braille value sampled at that edge. There is no history.
- rst asserted mid-operation forces the reset values immediately, regardless of clk.

Test Plan:
- Reset: rst=1 with braille=100100 -> digit_1=digit_2=0000000, valid=0. Release rst, one edge later -> 67: digit_1=1011111, digit_2=1110000, valid=1.
- Stream one value per cycle, 100100, 101110, 101010, 111100, 111110, 010111, 101111, 101011 -> 67, 78, 79, 80, 81, 87, 89, 90, each appearing 1 cycle after its input. Example: 78 = digit_1 1110000, digit_2 1111111. Example: 90 = digit_1 1111011, digit_2 1111110.
- Boundaries: 100000 (A) -> 65 = 1011111/1011011. 110100 (F) -> 70 = 1110000/1111110. 010110 (J) -> 74 = 1110000/0110011.
- Invalid inputs: 000000, 111111, 000001 -> both digits 0000001, valid=0. Next cycle a valid 111010 (R) -> 82 = 1111111/1101101, valid=1.
- Async reset mid-stream: assert rst between clock edges -> outputs blank and valid=0 without waiting for a clk edge. Outputs hold through further edges until rst is deasserted.
- Exhaustive sweep of all 64 inputs -> exactly 26 give valid=1 with the table values above; the rest give the dash pattern.
